// File: rtl/ap_ctrl_stat_pkg.sv
// ============================================================================
// Module : ap_ctrl_stat_pkg
// Brief  : Shared types and default widths for the ap_ctrl_hs stat monitor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ap_ctrl_stat_pkg;

  localparam int c_def_cnt_w      = 32;
  localparam int c_def_fifo_depth = 4;
  localparam int c_rec_id_w       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_END   = 2'd3
  } mon_state_t;

  // Field order matches the packed record word carried through the FIFO.
  typedef struct packed {
    logic [c_rec_id_w-1:0]  id;
    logic [c_def_cnt_w-1:0] txn;
    logic [c_def_cnt_w-1:0] latency;
    logic [c_def_cnt_w-1:0] interval;
  } stat_rec_t;

endpackage

`default_nettype wire

// File: rtl/stat_rec_fifo.sv
// ============================================================================
// Module : stat_rec_fifo
// Brief  : First-word-fall-through record FIFO, async active-low reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stat_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr;
  logic [c_aw-1:0]  r_rd;
  logic [c_cw-1:0]  r_cnt;
  logic             w_pop;
  logic             w_push;

  assign valid  = (r_cnt != '0);
  assign full   = (r_cnt == c_cw'(DEPTH));
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rd];
  assign w_pop  = pop && valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= wdata;
        r_wr        <= r_wr + c_aw'(1);
      end
      if (w_pop) r_rd <= r_rd + c_aw'(1);
      r_cnt <= r_cnt + c_cw'(w_push) - c_cw'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ap_ctrl_stat_monitor.sv
// ============================================================================
// Module : ap_ctrl_stat_monitor
// Brief  : Observes an ap_ctrl_hs handshake and emits per-transaction records.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ap_ctrl_stat_monitor
  import ap_ctrl_stat_pkg::*;
#(
  parameter logic [7:0] MOD_ID     = 8'd0,
  parameter int         CNT_W      = c_def_cnt_w,
  parameter int         FIFO_DEPTH = c_def_fifo_depth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [7:0]       rec_id,
  output logic [CNT_W-1:0] rec_txn,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [15:0]      drop_cnt,
  output logic             err_unexp_done,
  output logic             err_start_ovf,
  output logic             flushed
);

  localparam int c_rec_w = c_rec_id_w + 3 * CNT_W;
  localparam int c_fcw   = $clog2(FIFO_DEPTH) + 1;

  mon_state_t       r_state;
  logic [CNT_W-1:0] r_ts, r_q0, r_q1, r_txn, r_last_start;
  logic [1:0]       r_qcnt;
  logic             r_start_pend, r_have_last, r_err_unexp, r_err_ovf;
  logic [15:0]      r_drop;

  logic             w_active, w_start_ev, w_done_ev, w_q_pop, w_q_push, w_ovf;
  logic [1:0]       w_qcnt_nxt;
  logic [CNT_W-1:0] w_start_ts, w_latency, w_interval;
  logic [c_rec_w-1:0] w_wdata, w_rdata;
  logic             w_fifo_full, w_pop, w_drop;
  logic [c_fcw-1:0] w_fifo_count;

  assign w_active   = (r_state == ST_IDLE) || (r_state == ST_BUSY);
  assign w_start_ev = w_active && ap_start && !r_start_pend;
  assign w_done_ev  = w_active && ap_done && ap_continue;

  // A done with an empty queue consumes a same-cycle start directly.
  assign w_q_pop    = w_done_ev && (r_qcnt != 2'd0);
  assign w_q_push   = w_start_ev && !(w_done_ev && r_qcnt == 2'd0) &&
                      ((r_qcnt != 2'd2) || w_done_ev);
  assign w_ovf      = w_start_ev && (r_qcnt == 2'd2) && !w_done_ev;
  assign w_qcnt_nxt = r_qcnt + {1'b0, w_q_push} - {1'b0, w_q_pop};

  assign w_start_ts = (r_qcnt != 2'd0) ? r_q0 : r_ts;
  assign w_latency  = r_ts - w_start_ts;
  assign w_interval = r_have_last ? (w_start_ts - r_last_start) : '0;
  assign w_wdata    = {MOD_ID, r_txn, w_latency, w_interval};

  assign w_pop  = rec_valid && rec_ready;
  assign w_drop = w_done_ev && w_fifo_full && !w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_ts         <= '0;
      r_q0         <= '0;
      r_q1         <= '0;
      r_qcnt       <= '0;
      r_txn        <= '0;
      r_last_start <= '0;
      r_have_last  <= 1'b0;
      r_start_pend <= 1'b0;
      r_err_unexp  <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_drop       <= '0;
    end else begin
      if (r_ts != '1) r_ts <= r_ts + CNT_W'(1);

      if (ap_ready)        r_start_pend <= 1'b0;
      else if (w_start_ev) r_start_pend <= 1'b1;

      case ({w_q_pop, w_q_push})
        2'b10: r_q0 <= r_q1;
        2'b01: if (r_qcnt == 2'd0) r_q0 <= r_ts; else r_q1 <= r_ts;
        2'b11: begin
          if (r_qcnt == 2'd1) r_q0 <= r_ts;
          else begin
            r_q0 <= r_q1;
            r_q1 <= r_ts;
          end
        end
        default: ;
      endcase
      r_qcnt <= w_qcnt_nxt;

      if (w_done_ev) begin
        r_have_last  <= 1'b1;
        r_last_start <= w_start_ts;
        if (r_txn != '1) r_txn <= r_txn + CNT_W'(1);
        if (r_qcnt == 2'd0 && !w_start_ev) r_err_unexp <= 1'b1;
      end
      if (w_ovf) r_err_ovf <= 1'b1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;

      case (r_state)
        ST_IDLE, ST_BUSY: begin
          if (finish)                r_state <= ST_DRAIN;
          else if (w_qcnt_nxt != '0) r_state <= ST_BUSY;
          else                       r_state <= ST_IDLE;
        end
        // No pushes are possible here, so look one pop ahead.
        ST_DRAIN: if (!rec_valid || (w_fifo_count == c_fcw'(1) && w_pop))
                    r_state <= ST_END;
        default:  r_state <= ST_END;
      endcase
    end
  end

  stat_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_rec_w)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_done_ev),
    .wdata (w_wdata),
    .pop   (rec_ready),
    .rdata (w_rdata),
    .valid (rec_valid),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

  assign rec_id         = w_rdata[c_rec_w-1 -: 8];
  assign rec_txn        = w_rdata[3*CNT_W-1 -: CNT_W];
  assign rec_latency    = w_rdata[2*CNT_W-1 -: CNT_W];
  assign rec_interval   = w_rdata[CNT_W-1:0];
  assign drop_cnt       = r_drop;
  assign err_unexp_done = r_err_unexp;
  assign err_start_ovf  = r_err_ovf;
  assign flushed        = (r_state == ST_END);

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_stat_monitor.sv
// ============================================================================
// Module : tb_ap_ctrl_stat_monitor
// Brief  : Directed scenarios plus random traffic against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ap_ctrl_stat_monitor;

  localparam logic [7:0] c_mod_id = 8'hA5;
  localparam int         c_depth  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ap_start = 0, ap_ready = 0, ap_done = 0, ap_continue = 0;
  logic        finish = 0, rec_ready = 0;
  logic        rec_valid;
  logic [7:0]  rec_id;
  logic [31:0] rec_txn, rec_latency, rec_interval;
  logic [15:0] drop_cnt;
  logic        err_unexp_done, err_start_ovf, flushed;

  always #5 clock = ~clock;

  ap_ctrl_stat_monitor #(
    .MOD_ID     (c_mod_id),
    .CNT_W      (32),
    .FIFO_DEPTH (c_depth)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_continue    (ap_continue),
    .finish         (finish),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_id         (rec_id),
    .rec_txn        (rec_txn),
    .rec_latency    (rec_latency),
    .rec_interval   (rec_interval),
    .drop_cnt       (drop_cnt),
    .err_unexp_done (err_unexp_done),
    .err_start_ovf  (err_start_ovf),
    .flushed        (flushed)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] txn, lat, intv;
  } rec_t;

  int          n_total = 0;
  int          n_bad   = 0;

  // Reference model: outstanding starts and held records as plain queues.
  logic [31:0] m_ts, m_txn, m_last;
  logic [31:0] m_q[$];
  rec_t        m_fifo[$];
  bit          m_pend, m_have, m_err_u, m_err_o;
  int          m_mode;  // 0 monitoring, 1 draining, 2 finished
  logic [15:0] m_drop;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_txn = 0; m_last = 0; m_q.delete(); m_fifo.delete();
    m_pend = 0; m_have = 0; m_err_u = 0; m_err_o = 0; m_mode = 0; m_drop = 0;
  endtask

  task automatic model_eval(input bit s, input bit r, input bit d, input bit c,
                            input bit fin, input bit rr);
    bit          sev, dev, pop, consumed;
    logic [31:0] st;
    rec_t        rec;
    pop      = rr && (m_fifo.size() > 0);
    sev      = (m_mode == 0) && s && !m_pend;
    dev      = (m_mode == 0) && d && c;
    consumed = 0;
    st       = 0;
    rec      = '{default: 0};
    if (dev) begin
      if (m_q.size() > 0) st = m_q.pop_front();
      else begin
        st = m_ts;
        if (sev) consumed = 1; else m_err_u = 1;
      end
      rec.id   = c_mod_id;
      rec.txn  = m_txn;
      rec.lat  = m_ts - st;
      rec.intv = m_have ? st - m_last : 32'd0;
      m_have = 1;
      m_last = st;
      if (m_txn != 32'hFFFF_FFFF) m_txn++;
    end
    if (sev && !consumed) begin
      if (m_q.size() < 2) m_q.push_back(m_ts); else m_err_o = 1;
    end
    if (pop) void'(m_fifo.pop_front());
    if (dev) begin
      if (m_fifo.size() < c_depth) m_fifo.push_back(rec);
      else if (m_drop != 16'hFFFF) m_drop++;
    end
    if (r) m_pend = 0; else if (sev) m_pend = 1;
    if (m_mode == 0 && fin) m_mode = 1;
    else if (m_mode == 1 && m_fifo.size() == 0) m_mode = 2;
    if (m_ts != 32'hFFFF_FFFF) m_ts++;
  endtask

  task automatic check_outputs();
    check_val("rec_valid", rec_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      check_val("rec_id", rec_id, m_fifo[0].id);
      check_val("rec_txn", rec_txn, m_fifo[0].txn);
      check_val("rec_latency", rec_latency, m_fifo[0].lat);
      check_val("rec_interval", rec_interval, m_fifo[0].intv);
    end
    check_val("drop_cnt", drop_cnt, m_drop);
    check_val("err_unexp_done", err_unexp_done, m_err_u);
    check_val("err_start_ovf", err_start_ovf, m_err_o);
    check_val("flushed", flushed, m_mode == 2);
  endtask

  // One clock: check current outputs, apply inputs, advance model and DUT.
  task automatic cyc(input bit s, input bit r, input bit d, input bit c,
                     input bit fin, input bit rr);
    check_outputs();
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c;
    finish = fin; rec_ready = rr;
    model_eval(s, r, d, c, fin, rr);
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_valid"}, rec_valid, 1'b0);
    check_val({tag, "_fields"}, {rec_id, rec_txn, rec_latency, rec_interval}, 0);
    check_val({tag, "_drop"}, drop_cnt, 16'd0);
    check_val({tag, "_errs"}, {err_unexp_done, err_start_ovf}, 2'b00);
    check_val({tag, "_flushed"}, flushed, 1'b0);
  endtask

  task automatic do_reset();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    finish = 0; rec_ready = 0;
    reset = 1'b0;
    #1;
    check_reset_values("rst_async");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    check_reset_values("rst_release");
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // Single transaction: start at ts=5, done at ts=12.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 1);
    check_val("s1_ts_start", m_ts, 32'd5);
    cyc(1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    check_val("s1_valid", rec_valid, 1'b1);
    check_val("s1_rec", {rec_id, rec_txn, rec_latency, rec_interval},
              {c_mod_id, 32'd0, 32'd7, 32'd0});
    cyc(0, 0, 0, 1, 0, 1);

    // Overlapped starts at ts=10 and ts=14, dones at ts=20 and ts=24.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 0);
    check_val("s2_rec0", {rec_latency, rec_interval}, {32'd10, 32'd0});
    cyc(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    check_val("s2_rec1", {rec_latency, rec_interval}, {32'd10, 32'd4});
    check_val("s2_ovf", err_start_ovf, 1'b0);
    cyc(0, 0, 0, 1, 0, 1);

    // Backpressure: six transactions into a four-deep FIFO.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
    end
    check_val("s3_drop", drop_cnt, 16'd2);
    check_val("s3_first_txn", rec_txn, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_val("s3_drain_valid", rec_valid, 1'b1);
      check_val("s3_drain_txn", rec_txn, k);
      cyc(0, 0, 0, 1, 0, 1);
    end
    check_val("s3_empty", rec_valid, 1'b0);

    // ap_done held while ap_continue is low.
    do_reset();
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 1, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1);
    check_val("s4_no_rec", rec_valid, 1'b0);
    cyc(0, 0, 1, 1, 0, 1);
    check_val("s4_latency", rec_latency, 32'd5);
    cyc(0, 0, 0, 1, 0, 1);
    check_val("s4_single", rec_valid, 1'b0);

    // Unexpected done, then start-queue overflow.
    do_reset();
    cyc(0, 0, 1, 1, 0, 0);
    check_val("s5_lat0", rec_latency, 32'd0);
    check_val("s5_unexp", err_unexp_done, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0, 1);
    check_val("s5_ovf", err_start_ovf, 1'b1);
    cyc(0, 0, 0, 1, 0, 1);

    // Finish with two records held, drain, then ignored traffic.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
    end
    cyc(0, 0, 0, 1, 1, 0);
    check_val("s6_not_flushed", flushed, 1'b0);
    cyc(0, 0, 0, 1, 0, 1);
    check_val("s6_mid_drain", {rec_valid, flushed}, 2'b10);
    cyc(0, 0, 0, 1, 0, 1);
    check_val("s6_flushed", flushed, 1'b1);
    cyc(1, 1, 0, 1, 0, 1);
    cyc(0, 0, 1, 1, 0, 1);
    check_val("s6_ignored", {rec_valid, flushed}, 2'b01);
    cyc(0, 0, 0, 1, 0, 1);

    // Reset while a transaction is outstanding.
    do_reset();
    cyc(1, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 1, 1, 0, 0);
    check_val("s7_no_stale_start", err_unexp_done, 1'b1);

    // Random traffic with a reset and a late finish.
    do_reset();
    for (int n = 0; n < 1800; n++) begin
      if (n == 700) do_reset();
      cyc(($urandom % 3) == 0, $urandom % 2, ($urandom % 4) == 0,
          ($urandom % 4) != 0, n == 1500, $urandom % 2);
    end
    check_outputs();
    check_val("rand_flushed", flushed, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ap_ctrl_stat_monitor.md
AP_CTRL_STAT_MONITOR -- requirements
Module: ap_ctrl_stat_monitor

Interface
REQ-001 SHALL have parameter MOD_ID, default 0, the 8-bit module index copied into every record.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the timestamp, latency, interval and transaction counters.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the number of record entries (power of 2, ≥2).
REQ-004 SHALL have port clock  in  1  the single clock.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports ap_start, ap_ready, ap_done, ap_continue  in  1 each  the observed ap_ctrl_hs handshake (tie ap_continue to 1 when absent).
REQ-007 SHALL have port finish  in  1  end of simulation/test.
REQ-008 SHALL have ports rec_valid out 1, rec_ready in 1  the record stream handshake.
REQ-009 SHALL have record ports rec_id out 8, rec_txn out CNT_W, rec_latency out CNT_W, rec_interval out CNT_W.
REQ-010 SHALL have ports drop_cnt out 16, err_unexp_done out 1, err_start_ovf out 1, flushed out 1.

Function
REQ-011 SHALL run a free-running timestamp counter ts, incrementing every cycle and saturating at all-ones.
REQ-012 SHALL raise a start event in a cycle where ap_start=1 and start_pend=0; start_pend SHALL set on a start event and clear in any cycle where ap_ready=1, with clear winning when both occur in the same cycle.
REQ-013 SHALL push ts into a 2-entry start queue on each start event; a start event with the queue full SHALL be dropped and SHALL set err_start_ovf (sticky).
REQ-014 SHALL raise a done event in a cycle where ap_done=1 and ap_continue=1.
REQ-015 On a done event SHALL pop the queue and form a record: latency=ts−popped; a start and done in the same cycle with the queue empty SHALL give latency 0.
REQ-016 A done event with the queue empty and no same-cycle start SHALL give latency 0 and SHALL set err_unexp_done (sticky).
REQ-017 interval SHALL be the ts of this transaction's start minus the ts of the previous start; the first transaction SHALL report interval 0.
REQ-018 rec_txn SHALL be a 0-based, saturating count of done events.
REQ-019 SHALL push each record into the FIFO; if the FIFO is full and no pop occurs that cycle, the record SHALL be dropped and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-020 A push and pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-021 The FIFO SHALL be first-word-fall-through: rec_valid=1 whenever the FIFO is non-empty, and a pop SHALL occur on rec_valid and rec_ready both 1.
REQ-022 The record fields SHALL remain stable while rec_valid=1 and rec_ready=0.
REQ-023 The FSM SHALL have states IDLE (queue empty), BUSY (queue non-empty), DRAIN and END.
REQ-024 finish=1 SHALL move the FSM from any state to DRAIN; events in the finish cycle are still captured and all later events are ignored.
REQ-025 DRAIN SHALL move to END when the FIFO is empty.
REQ-026 flushed SHALL be 1 only in END; END SHALL be left only by reset.
REQ-027 Record latency SHALL be 1 cycle: a record is visible on rec_* the cycle after its done event.

Reset
REQ-028 While reset=0 SHALL asynchronously clear ts, start_pend, the queue, the FIFO pointers, the counters, the error flags and the FIFO record contents to 0, and SHALL force the state to IDLE.
REQ-029 After release, outputs SHALL read rec_valid=0, flushed=0, drop_cnt=0, err_*=0 and all record fields 0.
REQ-030 A reset mid-transaction SHALL discard outstanding starts and queued records with no partial record emitted.

Structure
REQ-031 The state enum, record struct (id, txn, latency, interval) and default widths SHALL live in package ap_ctrl_stat_pkg.
REQ-032 The FIFO SHALL be one sub-module, stat_rec_fifo (parameterised depth/width, FWFT, async active-low reset).

Verification
REQ-033 Scenario: start at ts=5 and held until ready at ts=5, done at ts=12, rec_ready=1 -> one record {id=MOD_ID, txn=0, latency=7, interval=0} with rec_valid at ts=13.
REQ-034 Scenario: overlapped starts at ts=10 and ts=14 (ready each time) with dones at ts=20 and ts=24 -> records latency 10/10, interval 0/4, err_start_ovf=0.
REQ-035 Scenario: rec_ready=0 for 6 transactions with FIFO_DEPTH=4 -> 4 records held with the first stable, drop_cnt=2; then rec_ready=1 -> exactly 4 records drain in order.
REQ-036 Scenario: ap_done=1 with ap_continue=0 for 3 cycles, then ap_continue=1 -> exactly one record, latency measured to the continue cycle.
REQ-037 Scenario: done with no prior start -> latency=0 and err_unexp_done=1; third start while 2 outstanding -> err_start_ovf=1.
REQ-038 Scenario: finish with 2 records queued, then drain -> flushed=1 one cycle after the last pop; a later start/done produces no record; reset mid-BUSY -> all outputs return to their reset values.
